// File: rtl/interleaver_bank_scheduler_if.sv
// Handshake and bank-port bundle between the interleaver scheduler and its environment.
interface interleaver_bank_scheduler_if;
   localparam int unsigned AW = 8;
   localparam int unsigned NBANK = 2;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    wraddr;
   logic             wren_A;
   logic             wren_B;
   logic [AW-1:0]    rdaddr;
   logic             rden_A;
   logic             rden_B;
   logic             q_A;
   logic             q_B;
   logic             out_valid;
   logic             out_ready;
   logic             q;
   logic [NBANK-1:0] bank_full;

   // Environment side: writer, downstream consumer and the two bank RAMs
   modport master (
      output flush, in_valid, q_A, q_B, out_ready,
      input  in_ready, wraddr, wren_A, wren_B, rdaddr, rden_A, rden_B,
             out_valid, q, bank_full
   );

   // Scheduler side
   modport slave (
      input  flush, in_valid, q_A, q_B, out_ready,
      output in_ready, wraddr, wren_A, wren_B, rdaddr, rden_A, rden_B,
             out_valid, q, bank_full
   );
endinterface

// File: rtl/interleaver_bank_scheduler.sv
// Ping-pong scheduler for a two-bank block interleaver: one bank fills in
// linear order while the other drains in column order (16 rows x 12 columns).
module interleaver_bank_scheduler #(
   parameter int unsigned NCBPS = 192
) (
   input  logic                         clk,
   input  logic                         resetN,
   interleaver_bank_scheduler_if.slave  bus
);
   localparam int unsigned AW         = 8;
   localparam int unsigned NROW       = 16;
   localparam logic [AW-1:0] CNT_LAST = AW'(NCBPS - 1);
   localparam logic [AW-1:0] COL_STEP = AW'(NCBPS / NROW);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_e;

   bank_state_e   bank_q [2];
   bank_state_e   bank_d [2];
   logic          w_sel_q, w_sel_d;
   logic          r_sel_q, r_sel_d;
   logic          last_sel_q, last_sel_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic          ready_en_q, ready_en_d;

   logic          wr_open_c;
   logic          rd_avail_c;
   logic          in_ready_c;
   logic          wr_acc_c;
   logic          rd_iss_c;
   logic          wr_last_c;
   logic          rd_last_c;
   logic [AW-1:0] rd_row_c;
   logic [AW-1:0] rd_col_c;

   // State register for both bank FSMs and the pointer/counter datapath
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         bank_q[0]   <= EMPTY;
         bank_q[1]   <= EMPTY;
         w_sel_q     <= 1'b0;
         r_sel_q     <= 1'b0;
         last_sel_q  <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         bank_q[0]   <= bank_d[0];
         bank_q[1]   <= bank_d[1];
         w_sel_q     <= w_sel_d;
         r_sel_q     <= r_sel_d;
         last_sel_q  <= last_sel_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         ready_en_q  <= ready_en_d;
      end
   end

   // Handshake decode; in_ready depends only on registered state and flush
   always_comb begin
      wr_open_c  = (bank_q[w_sel_q] == EMPTY) || (bank_q[w_sel_q] == FILLING);
      rd_avail_c = (bank_q[r_sel_q] == FULL)  || (bank_q[r_sel_q] == DRAINING);
      in_ready_c = ready_en_q && wr_open_c && !bus.flush;
      wr_acc_c   = bus.in_valid && in_ready_c;
      rd_iss_c   = rd_avail_c && (!out_valid_q || bus.out_ready) && !bus.flush;
      wr_last_c  = (wr_cnt_q == CNT_LAST);
      rd_last_c  = (rd_cnt_q == CNT_LAST);
   end

   // Bank FSM next state; writer and reader always target different banks
   always_comb begin
      bank_d[0] = bank_q[0];
      bank_d[1] = bank_q[1];
      if (bus.flush) begin
         bank_d[0] = EMPTY;
         bank_d[1] = EMPTY;
      end else begin
         if (wr_acc_c) begin
            if (wr_last_c) bank_d[w_sel_q] = FULL;
            else           bank_d[w_sel_q] = FILLING;
         end
         if (rd_iss_c) begin
            if (rd_last_c) bank_d[r_sel_q] = EMPTY;
            else           bank_d[r_sel_q] = DRAINING;
         end
      end
   end

   // Counter, pointer and output-valid next state
   always_comb begin
      w_sel_d     = w_sel_q;
      r_sel_d     = r_sel_q;
      last_sel_d  = last_sel_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      ready_en_d  = 1'b1;
      if (bus.flush) begin
         w_sel_d     = 1'b0;
         r_sel_d     = 1'b0;
         last_sel_d  = 1'b0;
         wr_cnt_d    = '0;
         rd_cnt_d    = '0;
         out_valid_d = 1'b0;
      end else begin
         if (wr_acc_c) begin
            if (wr_last_c) begin
               wr_cnt_d = '0;
               w_sel_d  = ~w_sel_q;
            end else begin
               wr_cnt_d = wr_cnt_q + AW'(1);
            end
         end
         if (rd_iss_c) begin
            last_sel_d = r_sel_q;
            if (rd_last_c) begin
               rd_cnt_d = '0;
               r_sel_d  = ~r_sel_q;
            end else begin
               rd_cnt_d = rd_cnt_q + AW'(1);
            end
         end
         // A fresh issue always produces a bit; otherwise hold until taken
         if (rd_iss_c)           out_valid_d = 1'b1;
         else if (bus.out_ready) out_valid_d = 1'b0;
      end
   end

   // Outputs: bank strobes, column-order read address, output mux
   always_comb begin
      rd_row_c      = {4'b0000, rd_cnt_q[3:0]};
      rd_col_c      = {4'b0000, rd_cnt_q[7:4]};
      bus.in_ready  = in_ready_c;
      bus.wraddr    = wr_cnt_q;
      bus.wren_A    = wr_acc_c && !w_sel_q;
      bus.wren_B    = wr_acc_c &&  w_sel_q;
      bus.rdaddr    = AW'(COL_STEP * rd_row_c) + rd_col_c;
      bus.rden_A    = rd_iss_c && !r_sel_q;
      bus.rden_B    = rd_iss_c &&  r_sel_q;
      bus.out_valid = out_valid_q;
      // RAM output is held while its rden is low, so a stalled bit stays put
      bus.q         = out_valid_q && (last_sel_q ? bus.q_B : bus.q_A);
      bus.bank_full[0] = (bank_q[0] == FULL) || (bank_q[0] == DRAINING);
      bus.bank_full[1] = (bank_q[1] == FULL) || (bank_q[1] == DRAINING);
   end

endmodule

// File: tb/tb_interleaver_bank_scheduler.sv
// Directed bench for interleaver_bank_scheduler with behavioural bank RAMs.
module tb_interleaver_bank_scheduler;
   localparam int unsigned NCBPS = 192;
   localparam int NVEC = 10;

   typedef struct packed {
      logic       flush;
      logic       in_valid;
      logic       out_ready;
      logic       exp_ready;
      logic       exp_wren_a;
      logic       exp_wren_b;
      logic [7:0] exp_wraddr;
      logic       exp_out_valid;
      logic [1:0] exp_bank_full;
   } vec_t;

   logic clk = 1'b0;
   logic resetN;
   logic din = 1'b0;
   logic qa_r = 1'b0;
   logic qb_r = 1'b0;
   logic mem_a [256];
   logic mem_b [256];

   int n_checks = 0;
   int n_fail   = 0;
   logic got_q   [$];
   logic wr_hist [$];
   logic prev_stall = 1'b0;
   logic prev_q     = 1'b0;

   vec_t tbl [NVEC];
   int spot_k [4] = '{1, 16, 17, 191};
   int spot_a [4] = '{12, 1, 13, 191};
   int gaps, nacc, nw, nb, spot_i;

   always #5 clk = ~clk;

   interleaver_bank_scheduler_if bus_if ();

   interleaver_bank_scheduler #(.NCBPS(NCBPS)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus_if)
   );

   assign bus_if.q_A = qa_r;
   assign bus_if.q_B = qb_r;

   // Bank RAMs: one-cycle read latency, output held while rden is low
   always @(posedge clk) begin
      if (bus_if.wren_A) mem_a[bus_if.wraddr] <= din;
      if (bus_if.wren_B) mem_b[bus_if.wraddr] <= din;
      if (bus_if.rden_A) qa_r <= mem_a[bus_if.rdaddr];
      if (bus_if.rden_B) qb_r <= mem_b[bus_if.rdaddr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int perm(input int k);
      return 12 * (k % 16) + k / 16;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Compare captured output bits against the column-permuted write history
   task automatic check_stream(input string name, input int nblk, input int ngot);
      int bad;
      int idx;
      bad = 0;
      check({name, "_count"}, 32'(got_q.size()), 32'(ngot));
      for (int i = 0; i < got_q.size(); i++) begin
         idx = (i / 192) * 192 + perm(i % 192);
         if (i >= nblk * 192 || idx >= wr_hist.size()) bad++;
         else if (got_q[i] !== wr_hist[idx]) bad++;
      end
      check({name, "_data"}, 32'(bad), 32'd0);
      got_q.delete();
      wr_hist.delete();
   endtask

   task automatic wait_out(input int n);
      for (int c = 0; c < 1000 && got_q.size() < n; c++) begin
         @(negedge clk);
         next_cycle();
      end
      repeat (4) begin
         @(negedge clk);
         next_cycle();
      end
   endtask

   // Per-cycle monitor: exclusivity, stall stability, output/write capture
   always @(negedge clk) begin
      if (resetN) begin
         check("excl", 32'((bus_if.wren_A && bus_if.wren_B) || (bus_if.rden_A && bus_if.rden_B) ||
                           (bus_if.wren_A && bus_if.rden_A) || (bus_if.wren_B && bus_if.rden_B)), 32'd0);
         if (prev_stall)
            check("hold", 32'({bus_if.out_valid, bus_if.q}), 32'({1'b1, prev_q}));
         if (bus_if.out_valid && bus_if.out_ready) got_q.push_back(bus_if.q);
         if (bus_if.wren_A || bus_if.wren_B) wr_hist.push_back(din);
      end
      prev_stall = resetN && !bus_if.flush && bus_if.out_valid && !bus_if.out_ready;
      prev_q     = bus_if.q;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout required finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      //            fl    iv    or    rdy   wA    wB    wraddr ov    bf
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'b00};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 2'b00};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 2'b00};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 2'b00};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'b00};
      tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 2'b00};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00};

      // Reset: write attempts ignored, everything idle
      resetN = 1'b0;
      bus_if.flush = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", 32'({bus_if.wren_A, bus_if.wren_B, bus_if.rden_A, bus_if.rden_B,
                                bus_if.out_valid, bus_if.q, bus_if.bank_full}), 32'd0);
      bus_if.in_valid = 1'b0;
      next_cycle();
      resetN = 1'b1;
      next_cycle();

      // Short write/flush vectors right after reset release
      for (int i = 0; i < NVEC; i++) begin
         bus_if.flush     = tbl[i].flush;
         bus_if.in_valid  = tbl[i].in_valid;
         bus_if.out_ready = tbl[i].out_ready;
         din = 1'($urandom);
         @(negedge clk);
         check($sformatf("vec%0d", i),
               32'({bus_if.in_ready, bus_if.wren_A, bus_if.wren_B, bus_if.wraddr,
                    bus_if.out_valid, bus_if.bank_full}),
               32'({tbl[i].exp_ready, tbl[i].exp_wren_a, tbl[i].exp_wren_b, tbl[i].exp_wraddr,
                    tbl[i].exp_out_valid, tbl[i].exp_bank_full}));
         next_cycle();
      end
      bus_if.flush = 1'b0;
      wr_hist.delete();
      got_q.delete();

      // Fill bank A with one block
      for (int i = 0; i < 192; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.out_ready = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         check("fill_a", 32'({bus_if.in_ready, bus_if.wren_A, bus_if.wren_B, bus_if.wraddr}),
               32'({1'b1, 1'b1, 1'b0, 8'(i)}));
         next_cycle();
      end
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      check("drain_first", 32'({bus_if.bank_full, bus_if.rden_A, bus_if.rden_B, bus_if.rdaddr, bus_if.out_valid}),
            32'({2'b01, 1'b1, 1'b0, 8'd0, 1'b0}));
      next_cycle();
      spot_i = 0;
      for (int k = 1; k < 192; k++) begin
         @(negedge clk);
         check("drain_a", 32'({bus_if.rden_A, bus_if.rden_B, bus_if.rdaddr, bus_if.out_valid}),
               32'({1'b1, 1'b0, 8'(perm(k)), 1'b1}));
         if (spot_i < 4 && k == spot_k[spot_i]) begin
            check($sformatf("rdaddr_k%0d", k), 32'(bus_if.rdaddr), 32'(spot_a[spot_i]));
            spot_i++;
         end
         next_cycle();
      end
      @(negedge clk);
      check("drain_end", 32'({bus_if.bank_full, bus_if.out_valid, bus_if.rden_A, bus_if.in_ready}),
            32'({2'b00, 1'b1, 1'b0, 1'b1}));
      next_cycle();
      wait_out(192);
      check("idle_valid", 32'(bus_if.out_valid), 32'd0);
      check_stream("block_a", 1, 192);

      // Four back-to-back blocks at full rate on both sides
      gaps = 0;
      for (int i = 0; i < 4 * 192; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.out_ready = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         if (!bus_if.in_ready) gaps++;
         next_cycle();
      end
      check("stream_gaps", 32'(gaps), 32'd0);
      bus_if.in_valid = 1'b0;
      wait_out(768);
      check_stream("stream4", 4, 768);

      // One block drained with out_ready toggling every cycle
      bus_if.out_ready = 1'b0;
      for (int i = 0; i < 192; i++) begin
         bus_if.in_valid = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         next_cycle();
      end
      bus_if.in_valid = 1'b0;
      for (int c = 0; c < 1000 && got_q.size() < 192; c++) begin
         bus_if.out_ready = c[0];
         @(negedge clk);
         next_cycle();
      end
      bus_if.out_ready = 1'b1;
      wait_out(192);
      check_stream("toggle", 1, 192);

      // Both banks full with the consumer stalled
      bus_if.out_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 384; i++) begin
         bus_if.in_valid = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         if (bus_if.wren_A || bus_if.wren_B) nacc++;
         next_cycle();
      end
      check("both_fill_acc", 32'(nacc), 32'd384);
      for (int i = 0; i < 3; i++) begin
         bus_if.in_valid = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         check("both_full", 32'({bus_if.bank_full, bus_if.in_ready, bus_if.wren_A, bus_if.wren_B}),
               32'({2'b11, 1'b0, 1'b0, 1'b0}));
         next_cycle();
      end
      bus_if.in_valid = 1'b0;
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      check("drain_order", 32'({bus_if.rden_A, bus_if.rden_B}), 32'({1'b1, 1'b0}));
      next_cycle();
      wait_out(384);
      check_stream("both", 2, 384);

      // Flush with A at wr_cnt=100 and B draining at rd_cnt=50
      bus_if.out_ready = 1'b0;
      for (int i = 0; i < 384; i++) begin
         bus_if.in_valid = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         next_cycle();
      end
      nw = 0;
      nb = 0;
      for (int c = 0; c < 1000 && !(nw == 100 && nb == 50); c++) begin
         bus_if.in_valid  = (nw < 100);
         bus_if.out_ready = (nb < 50);
         din = 1'($urandom);
         @(negedge clk);
         if (bus_if.wren_A) nw++;
         if (bus_if.rden_B) nb++;
         next_cycle();
      end
      check("flush_wr_cnt", 32'(nw), 32'd100);
      check("flush_rd_cnt", 32'(nb), 32'd50);
      bus_if.flush = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.out_ready = 1'b0;
      @(negedge clk);
      check("flush_cycle", 32'({bus_if.in_ready, bus_if.wren_A, bus_if.wren_B, bus_if.rden_A, bus_if.rden_B}),
            32'd0);
      next_cycle();
      bus_if.flush = 1'b0;
      din = 1'($urandom);
      @(negedge clk);
      check("flush_after", 32'({bus_if.bank_full, bus_if.out_valid, bus_if.in_ready, bus_if.wren_A,
                                bus_if.wren_B, bus_if.wraddr}),
            32'({2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}));
      next_cycle();
      check_stream("flush_pre", 2, 241);

      // Reset mid-block: A full and stalled, B partially written
      for (int i = 0; i < 241; i++) begin
         bus_if.in_valid = 1'b1;
         din = 1'($urandom);
         @(negedge clk);
         next_cycle();
      end
      check("pre_reset_full", 32'(bus_if.bank_full), 32'b01);
      resetN = 1'b0;
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      check("reset_mid", 32'({bus_if.wren_A, bus_if.wren_B, bus_if.rden_A, bus_if.rden_B,
                              bus_if.out_valid, bus_if.q, bus_if.bank_full}), 32'd0);
      next_cycle();
      resetN = 1'b1;
      next_cycle();
      @(negedge clk);
      check("post_reset", 32'({bus_if.in_ready, bus_if.wraddr, bus_if.bank_full, bus_if.out_valid}),
            32'({1'b1, 8'd0, 2'b00, 1'b0}));
      next_cycle();
      got_q.delete();
      wr_hist.delete();
      bus_if.out_ready = 1'b1;
      repeat (300) begin
         @(negedge clk);
         next_cycle();
      end
      check("no_stale_out", 32'(got_q.size()), 32'd0);
      check("no_stale_full", 32'(bus_if.bank_full), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
